// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared definitions for the program-counter sequencer:
//   - pc_seq_state_t : fetch/execute FSM states
//   - J_LT/J_EQ/J_GT : bit positions of the jump bits j2..j0 in an IR jump field
//   - PC_W_DEFAULT   : default PC / address width (matches pcount)
package pc_seq_pkg;

  localparam int unsigned PC_W_DEFAULT = 15;

  localparam int unsigned J_LT = 2;
  localparam int unsigned J_EQ = 1;
  localparam int unsigned J_GT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } pc_seq_state_t;

endpackage

// File: rtl/pc_jump_cond.sv
// pc_jump_cond
// Combinational jump decision for the current instruction.
// Ports:
//   is_c    in  1  IR holds a C-instruction (A-instructions never jump)
//   jmp     in  3  jump bits j2..j0 (lt, eq, gt)
//   alu_zr  in  1  ALU result is zero
//   alu_ng  in  1  ALU result is negative
//   o_take  out 1  jump is taken
module pc_jump_cond
  import pc_seq_pkg::*;
(
  input  logic       is_c,
  input  logic [2:0] jmp,
  input  logic       alu_zr,
  input  logic       alu_ng,
  output logic       o_take
);

  logic w_lt;
  logic w_eq;
  logic w_gt;

  assign w_lt = jmp[J_LT] & alu_ng;
  assign w_eq = jmp[J_EQ] & alu_zr;
  assign w_gt = jmp[J_GT] & ~alu_ng & ~alu_zr;

  assign o_take = is_c & (w_lt | w_eq | w_gt);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch/execute control FSM driving the pcount program counter.
// Ports:
//   clk50m, rst              clock (rising edge), async active-high reset
//   start, halt_req          leave IDLE/HALT; request halt at next commit
//   rom_req / rom_ack        instruction fetch handshake
//   is_c, jmp, alu_zr,
//   alu_ng, a_reg            current instruction jump info and target
//   mem_busy                 data-memory stall, holds EXEC
//   ir_we                    instruction-register write strobe
//   pc_en/pc_load/pc_inc,
//   pc_target                pcount control (Mealy, valid in commit cycle)
//   jump_taken               pulse on a taken jump
//   retired                  completed-instruction count (wraps)
//   busy, halted, fault      state decodes
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned W  = PC_W_DEFAULT,
  parameter int unsigned TO = 15
) (
  input  logic         clk50m,
  input  logic         rst,
  input  logic         start,
  input  logic         halt_req,
  output logic         rom_req,
  input  logic         rom_ack,
  input  logic         is_c,
  input  logic [2:0]   jmp,
  input  logic         alu_zr,
  input  logic         alu_ng,
  input  logic [W-1:0] a_reg,
  input  logic         mem_busy,
  output logic         ir_we,
  output logic         pc_en,
  output logic         pc_load,
  output logic         pc_inc,
  output logic [W-1:0] pc_target,
  output logic         jump_taken,
  output logic [15:0]  retired,
  output logic         busy,
  output logic         halted,
  output logic         fault
);

  // Counter holds the number of ack-less FETCH cycles already elapsed (0..TO-1).
  localparam int unsigned CW = (TO < 2) ? 1 : $clog2(TO);

  pc_seq_state_t r_state;
  pc_seq_state_t w_state_nxt;
  logic [CW-1:0] r_to_cnt;
  logic [15:0]   r_retired;
  logic          w_take;
  logic          w_commit;

  pc_jump_cond u_jump_cond (
    .is_c   (is_c),
    .jmp    (jmp),
    .alu_zr (alu_zr),
    .alu_ng (alu_ng),
    .o_take (w_take)
  );

  assign w_commit = (r_state == S_EXEC) && !mem_busy;

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_to_cnt  <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Counts only while staying in FETCH, so every entry starts from zero.
      if (r_state == S_FETCH && w_state_nxt == S_FETCH)
        r_to_cnt <= r_to_cnt + 1'b1;
      else
        r_to_cnt <= '0;
      if (w_commit)
        r_retired <= r_retired + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ir_we       = 1'b0;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_target   = '0;
    jump_taken  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (rom_ack) begin
          ir_we       = 1'b1;
          w_state_nxt = S_EXEC;
        end else if (r_to_cnt == CW'(TO - 1)) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_EXEC: begin
        if (!mem_busy) begin
          pc_en = 1'b1;
          if (w_take) begin
            pc_load    = 1'b1;
            pc_target  = a_reg;
            jump_taken = 1'b1;
          end else begin
            pc_inc = 1'b1;
          end
          w_state_nxt = halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rom_req = (r_state == S_FETCH);
  assign busy    = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign halted  = (r_state == S_HALT);
  assign fault   = (r_state == S_FAULT);
  assign retired = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int unsigned W  = 15;
  localparam int unsigned TO = 15;

  logic         clk50m = 1'b0;
  logic         rst;
  logic         start;
  logic         halt_req;
  logic         rom_req;
  logic         rom_ack;
  logic         is_c;
  logic [2:0]   jmp;
  logic         alu_zr;
  logic         alu_ng;
  logic [W-1:0] a_reg;
  logic         mem_busy;
  logic         ir_we;
  logic         pc_en;
  logic         pc_load;
  logic         pc_inc;
  logic [W-1:0] pc_target;
  logic         jump_taken;
  logic [15:0]  retired;
  logic         busy;
  logic         halted;
  logic         fault;

  int n_checks = 0;
  int n_err    = 0;
  int exp_ret  = 0;

  pc_sequencer #(.W(W), .TO(TO)) dut (
    .clk50m     (clk50m),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .rom_req    (rom_req),
    .rom_ack    (rom_ack),
    .is_c       (is_c),
    .jmp        (jmp),
    .alu_zr     (alu_zr),
    .alu_ng     (alu_ng),
    .a_reg      (a_reg),
    .mem_busy   (mem_busy),
    .ir_we      (ir_we),
    .pc_en      (pc_en),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .pc_target  (pc_target),
    .jump_taken (jump_taken),
    .retired    (retired),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk50m = ~clk50m;

  typedef struct {
    logic       isc;
    logic [2:0] j;
    logic       zr;
    logic       ng;
    logic       exp_take;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the ALU result falls in exactly one class (neg/zero/pos);
  // a C-instruction jumps when its jump bit for that class is set.
  function automatic logic model_take(input logic isc, input logic [2:0] j,
                                      input logic zr, input logic ng);
    int cls;
    if (!isc) return 1'b0;
    cls = ng ? 2 : (zr ? 1 : 0);
    return j[cls];
  endfunction

  // From IDLE or HALT: pulse start for one cycle; ends at start of first FETCH cycle.
  task automatic do_start();
    start = 1'b1;
    #1;
    chk("pre_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk50m);
    start = 1'b0;
  endtask

  // One instruction, beginning at the first FETCH cycle: d ack-wait cycles,
  // b mem_busy cycles, then commit. Ends 1 ns into the next cycle.
  task automatic run_instr(input int d, input int b, input logic isc,
                           input logic [2:0] j, input logic zr, input logic ng,
                           input logic [W-1:0] a, input logic hlt,
                           input logic exp_take);
    logic commit;
    for (int k = 0; k <= d; k++) begin
      rom_ack  = (k == d);
      mem_busy = 1'($urandom);
      halt_req = 1'($urandom);
      start    = 1'($urandom);
      #1;
      chk("fetch_rom_req", {31'd0, rom_req}, 32'd1);
      chk("fetch_ir_we", {31'd0, ir_we}, {31'd0, (k == d)});
      chk("fetch_pc_en", {31'd0, pc_en}, 32'd0);
      @(negedge clk50m);
    end
    for (int k = 0; k <= b; k++) begin
      commit   = (k == b);
      rom_ack  = 1'($urandom);
      mem_busy = !commit;
      is_c     = isc;
      jmp      = j;
      alu_zr   = zr;
      alu_ng   = ng;
      a_reg    = a;
      halt_req = commit ? hlt : 1'($urandom);
      start    = 1'($urandom);
      #1;
      chk("exec_rom_req", {31'd0, rom_req}, 32'd0);
      chk("exec_ir_we", {31'd0, ir_we}, 32'd0);
      chk("exec_pc_en", {31'd0, pc_en}, {31'd0, commit});
      chk("exec_pc_load", {31'd0, pc_load}, {31'd0, commit && exp_take});
      chk("exec_pc_inc", {31'd0, pc_inc}, {31'd0, commit && !exp_take});
      chk("exec_jump_taken", {31'd0, jump_taken}, {31'd0, commit && exp_take});
      chk("exec_pc_target", {17'd0, pc_target}, (commit && exp_take) ? {17'd0, a} : 32'd0);
      chk("exec_busy", {31'd0, busy}, 32'd1);
      @(negedge clk50m);
    end
    exp_ret  = (exp_ret + 1) & 32'hFFFF;
    rom_ack  = 1'b0;
    mem_busy = 1'b0;
    halt_req = 1'b0;
    start    = 1'b0;
    #1;
    chk("retired", {16'd0, retired}, exp_ret);
    chk("halted_after_commit", {31'd0, halted}, {31'd0, hlt});
    chk("rom_req_after_commit", {31'd0, rom_req}, {31'd0, !hlt});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; rom_ack = 1'b0; is_c = 1'b0;
    jmp = '0; alu_zr = 1'b0; alu_ng = 1'b0; a_reg = '0; mem_busy = 1'b0;

    // Expected taken sets per ALU class, written as explicit jmp lists.
    for (int jv = 0; jv < 8; jv++) begin
      vecs.push_back('{1'b1, 3'(jv), 1'b0, 1'b0, (jv inside {1, 3, 5, 7})});
      vecs.push_back('{1'b1, 3'(jv), 1'b1, 1'b0, (jv inside {2, 3, 6, 7})});
      vecs.push_back('{1'b1, 3'(jv), 1'b0, 1'b1, (jv inside {4, 5, 6, 7})});
    end
    vecs.push_back('{1'b0, 3'b111, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b111, 1'b0, 1'b1, 1'b0});

    @(negedge clk50m);
    @(negedge clk50m);
    #1;
    chk("reset_rom_req", {31'd0, rom_req}, 32'd0);
    chk("reset_pc_en", {31'd0, pc_en}, 32'd0);
    chk("reset_retired", {16'd0, retired}, 32'd0);
    chk("reset_state_flags", {29'd0, busy, halted, fault}, 32'd0);
    @(negedge clk50m);
    rst = 1'b0;

    // IDLE ignores ack and halt_req.
    rom_ack = 1'b1; halt_req = 1'b1;
    #1;
    chk("idle_ir_we", {31'd0, ir_we}, 32'd0);
    @(negedge clk50m);
    #1;
    chk("idle_stays", {31'd0, busy}, 32'd0);
    rom_ack = 1'b0; halt_req = 1'b0;

    do_start();
    // Ten back-to-back A-instructions, 2 cycles each.
    for (int i = 0; i < 10; i++)
      run_instr(0, 0, 1'b0, 3'($urandom), 1'($urandom), 1'b0, W'($urandom), 1'b0, 1'b0);
    chk("retired_ten", {16'd0, retired}, 32'd10);

    // Directed conditional jump: JEQ with zero, then not zero.
    run_instr(0, 0, 1'b1, 3'b010, 1'b1, 1'b0, 15'h001E, 1'b0, 1'b1);
    run_instr(0, 0, 1'b1, 3'b010, 1'b0, 1'b0, 15'h001E, 1'b0, 1'b0);

    // Jump matrix from the vector table.
    foreach (vecs[i])
      run_instr(0, 0, vecs[i].isc, vecs[i].j, vecs[i].zr, vecs[i].ng,
                W'($urandom), 1'b0, vecs[i].exp_take);

    // mem_busy for 3 EXEC cycles: commit on 4th EXEC cycle (5-cycle instruction).
    run_instr(0, 3, 1'b1, 3'b111, 1'b0, 1'b1, 15'h7FFF, 1'b0, 1'b1);

    // Last accepted ack cycle (cycle TO).
    run_instr(TO - 1, 0, 1'b0, 3'b000, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Halt at commit, hold 20 cycles, resume.
    run_instr(0, 1, 1'b0, 3'b000, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      rom_ack = 1'($urandom);
      halt_req = 1'($urandom);
      #1;
      chk("halt_hold_halted", {31'd0, halted}, 32'd1);
      chk("halt_hold_rom_req", {31'd0, rom_req}, 32'd0);
      chk("halt_hold_pc_en", {31'd0, pc_en}, 32'd0);
      @(negedge clk50m);
    end
    rom_ack = 1'b0; halt_req = 1'b0;
    do_start();
    run_instr(1, 0, 1'b1, 3'b001, 1'b0, 1'b0, 15'h0123, 1'b0, 1'b1);

    // Randomized instruction stream against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic isc, zr, ng, hlt;
      logic [2:0] j;
      int cls;
      isc = 1'($urandom);
      j   = 3'($urandom);
      cls = $urandom_range(2, 0);
      zr  = (cls == 1);
      ng  = (cls == 2);
      hlt = ($urandom_range(7, 0) == 0);
      run_instr($urandom_range(TO - 1, 0), $urandom_range(3, 0), isc, j, zr, ng,
                W'($urandom), hlt, model_take(isc, j, zr, ng));
      if (hlt) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk50m);
          #1;
          chk("rand_halt_hold", {31'd0, halted}, 32'd1);
        end
        @(negedge clk50m);
        do_start();
      end
    end

    // Timeout: TO ack-less FETCH cycles, then FAULT.
    for (int c = 0; c < TO; c++) begin
      rom_ack = 1'b0;
      #1;
      chk("timeout_rom_req", {31'd0, rom_req}, 32'd1);
      chk("timeout_no_fault", {31'd0, fault}, 32'd0);
      @(negedge clk50m);
    end
    #1;
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_rom_req", {31'd0, rom_req}, 32'd0);
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk50m);
      #1;
      chk("fault_sticky", {31'd0, fault}, 32'd1);
      chk("fault_busy", {31'd0, busy}, 32'd0);
    end
    start = 1'b0;

    // Reset clears fault; then asynchronous reset mid-FETCH.
    rst = 1'b1;
    #1;
    chk("rst_clears_fault", {31'd0, fault}, 32'd0);
    @(negedge clk50m);
    rst = 1'b0;
    exp_ret = 0;
    do_start();
    rom_ack = 1'b1;
    #1;
    chk("midfetch_ir_we", {31'd0, ir_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_rom_req", {31'd0, rom_req}, 32'd0);
    chk("async_rst_ir_we", {31'd0, ir_we}, 32'd0);
    chk("async_rst_flags", {29'd0, busy, halted, fault}, 32'd0);
    chk("async_rst_retired", {16'd0, retired}, 32'd0);
    @(negedge clk50m);
    rst = 1'b0;
    rom_ack = 1'b0;
    @(negedge clk50m);
    #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    @(negedge clk50m);
    do_start();
    run_instr(0, 0, 1'b0, 3'b000, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/execute control FSM that sequences the program counter (`pcount`) of the CPU core. It requests each instruction from instruction ROM over a req/ack handshake, waits out data-memory stalls, evaluates the jump condition of C-instructions from the ALU flags, and drives the counter's `en`/`load`/`inc`/`cnt_in` inputs. It sits between instruction memory, ALU flags, the A register and `pcount`, and also provides halt/resume and ROM-timeout fault handling.

## Interface
- `W`, 15: PC / address width, equal to `pcount` width.
- `TO`, 15: maximum FETCH cycles without `rom_ack` before FAULT (≥1).
- `clk50m`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  leave IDLE or HALT and begin fetching; ignored in other states.
- `halt_req`  in  1  level; honoured only at an instruction boundary.
- `rom_req`  out  1  instruction fetch request.
- `rom_ack`  in  1  instruction word valid on the ROM bus this cycle.
- `is_c`  in  1  current IR holds a C-instruction.
- `jmp`  in  3  jump bits j2..j0 (lt, eq, gt) of current IR.
- `alu_zr`, `alu_ng`  in  1 each  ALU zero / negative flags for current instruction.
- `a_reg`  in  W  jump target (A register, low W bits).
- `mem_busy`  in  1  data memory not done; stalls EXEC.
- `ir_we`  out  1  instruction-register write strobe.
- `pc_en`, `pc_load`, `pc_inc`  out  1 each  to `pcount` `en`/`load`/`inc`.
- `pc_target`  out  W  to `pcount` `cnt_in`.
- `jump_taken`  out  1  one-cycle pulse on a taken jump.
- `retired`  out  16  count of completed instructions.
- `busy`  out  1  state is FETCH or EXEC.
- `halted`  out  1  state is HALT.
- `fault`  out  1  state is FAULT.

## Operation
- States: IDLE, FETCH, EXEC, HALT, FAULT. Reset → IDLE. All outputs 0, `retired`=0, timeout counter=0.
- IDLE: `start` → FETCH. `halt_req`, `rom_ack` ignored.
- FETCH: `rom_req`=1. `rom_ack`=1 → `ir_we`=1 same cycle, next EXEC. Timeout counter cleared on entry, +1 each FETCH cycle without ack. After `TO` consecutive ack-less cycles → FAULT.
- EXEC: `mem_busy`=1 → hold, no PC control asserted. `mem_busy`=0 → commit cycle:
  - jump = `is_c` & ((j2&ng) | (j1&zr) | (j0&~ng&~zr)).
  - jump: `pc_en`=`pc_load`=1, `pc_target`=`a_reg`, `jump_taken`=1.
  - else: `pc_en`=`pc_inc`=1.
  - `retired`+1, wrapping 0xFFFF→0.
  - next HALT if `halt_req`=1 in the commit cycle, else FETCH.
- HALT: outputs idle. `start` → FETCH; PC is untouched, so execution resumes at the next instruction.
- FAULT: sticky; `fault`=1, no requests. Exit only via `rst`; `start` is ignored.
- `pc_load` and `pc_inc` are never both 1. `pc_target`=0 whenever `pc_load`=0.
- A-instructions (`is_c`=0) always increment. `jmp`=3'b111 is an unconditional jump.
- PC wrap-around is handled by `pcount`. The sequencer never inspects the PC value.

## Timing
- `rom_req`, `busy`, `halted`, `fault` are Moore outputs (state-decoded).
- `ir_we`, `pc_*`, `jump_taken` are Mealy: combinational from state and current inputs. `pcount` updates on the same rising edge as the commit.
- Minimum instruction time: 2 cycles (ack in the first FETCH cycle, `mem_busy`=0 in the first EXEC cycle). Each `mem_busy` cycle and each ack wait adds exactly 1 cycle.
- `rom_ack` is accepted in FETCH cycles 1..`TO`. With `TO`=1, only a first-cycle ack is accepted.
- `start` together with `halt_req` in IDLE: go to FETCH; the halt takes effect at the first commit.
- `rst` mid-operation clears state and outputs immediately, without waiting for a clock edge. `rom_req` drops asynchronously and any partial instruction is discarded.

## Structure
- Package `pc_seq_pkg`:
  - state enum `pc_seq_state_t`
  - jump-bit index constants `J_LT`=2, `J_EQ`=1, `J_GT`=0
  - default `W`
- Sub-module `pc_jump_cond`: purely combinational jump decision from `is_c`, `jmp`, `alu_zr`, `alu_ng`.
- The sequencer holds the FSM, timeout counter and `retired` counter. It is paired with `pcount` in the core top.

## Test plan
- Reset, `start`, ack every first FETCH cycle, `is_c`=0, `mem_busy`=0 for 10 instructions → `pc_inc` pulses every 2nd cycle, `retired`=10, `pc_load` never 1.
- C-instruction, `jmp`=3'b010, `alu_zr`=1, `a_reg`=15'h001E → `pc_load`=1, `pc_target`=15'h001E, `jump_taken`=1 for one cycle. Repeat with `alu_zr`=0 → `pc_inc` instead.
- Jump matrix: all 8 `jmp` values × (zr,ng) ∈ {(0,0),(1,0),(0,1)} → taken exactly per the jump equation. `jmp`=3'b111 is always taken.
- `mem_busy` high for 3 EXEC cycles → no `pc_en` during those cycles, commit on the 4th EXEC cycle, instruction time 5 cycles.
- `halt_req` asserted during EXEC → after commit `halted`=1 and `rom_req`=0 for 20 cycles. `start` → FETCH resumes and `retired` continues from its prior value.
- Hold `rom_ack` at 0 with `TO`=15 → FAULT after exactly 15 FETCH cycles, `fault`=1 persists through `start`. Assert `rst` mid-FETCH in another run → all outputs 0 immediately.
